// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_DEFAULT_DIV = 434;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO; read data is captured into a register on pop.
// Latency: an entry is poppable the cycle after its push; rdata valid the cycle after pop.
// Backpressure: push while full and pop while empty are ignored; caller watches full/empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] rdata_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = rdata_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage array: written on accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointers, occupancy and the registered pop data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rptr_q  <= rptr_q + AW'(1);
        rdata_q <= mem_q[rptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers bytes and serialises them as 8N1 frames, LSB first, at CLK_DIV clocks per bit.
// Latency: tx_en in cycle N drives the start bit from cycle N+2 when idle.
// Backpressure: tx_ready low when FIFO full; writes while full are dropped and flagged in overflow.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_DEFAULT_DIV,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          tx_en,
  input  logic [7:0]                    tx_data,
  input  logic                          ovf_clr,
  output logic                          txd,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
  localparam int          IW       = $clog2(UART_DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  tx_state_e                 state_q;
  logic [15:0]               cnt_q;
  logic [IW-1:0]             idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      txd_q;
  logic                      ovf_q;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_lvl;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (tx_en),
    .pop   (fifo_pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  // Pop from idle, or on the last stop-bit cycle so frames run back to back.
  always_comb begin
    fifo_pop = !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && (cnt_q == '0)));
  end

  // Frame sequencer: baud counter, bit index, shift register and registered txd.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
          if (fifo_pop) begin
            state_q <= ST_START;
            cnt_q   <= DIV_M1;
            txd_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt_q == '0) begin
            // Popped byte has been sitting in the FIFO read register since the pop.
            state_q <= ST_DATA;
            cnt_q   <= DIV_M1;
            idx_q   <= '0;
            shift_q <= fifo_rdata;
            txd_q   <= fifo_rdata[0];
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= DIV_M1;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
              idx_q   <= idx_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == '0) begin
            if (fifo_pop) begin
              state_q <= ST_START;
              cnt_q   <= DIV_M1;
              txd_q   <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear wins.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ovf_q <= 1'b0;
    end else if (tx_en && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign txd        = txd_q;
  assign overflow   = ovf_q;
  assign fifo_level = fifo_lvl;
  assign tx_ready   = !fifo_full;
  assign tx_busy    = (state_q != ST_IDLE) || (fifo_lvl != '0);

endmodule
